// File: rtl/packed_word_fifo_if.sv
// Storage container for packed_word_fifo: one packed 2-D word array.
// The owning module is the only writer, from its sequential block.
interface packed_word_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
endinterface

// File: rtl/packed_word_fifo.sv
// First-word-fall-through FIFO that buffers words from the packed-register stage.
// Every output is decoded from registered state only; nothing passes straight from inputs to outputs.
module packed_word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  packed_word_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem ();

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Handshake decode; a full FIFO refuses writes even if a pop happens in the same cycle.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == CNT_W'(0));
    push  = i_valid & ~full;
    pop   = i_ready & ~empty;
  end

  // Pointers, occupancy, storage and the sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      u_mem.mem <= '0;
    end else begin
      if (push) begin
        u_mem.mem[wr_ptr] <= i_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (i_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    o_ready    = ~full;
    o_valid    = ~empty;
    o_data     = u_mem.mem[rd_ptr];
    o_count    = count;
    o_overflow = overflow;
  end

endmodule

// File: tb/tb_packed_word_fifo.sv
// Directed bench for packed_word_fifo: a vector table for fill/drain/overflow/streaming,
// plus hand-written sequences for asynchronous reset and FWFT latency.
module tb_packed_word_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_count;
  logic       o_overflow;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       e_valid;
    logic       e_ready;
    logic [7:0] e_data;
    logic [2:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  packed_word_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic er, input logic [7:0] ed,
                         input logic [2:0] ec, input logic eo);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
    chk({tag, ".o_ready"}, 32'(o_ready), 32'(er));
    chk({tag, ".o_data"}, 32'(o_data), 32'(ed));
    chk({tag, ".o_count"}, 32'(o_count), 32'(ec));
    chk({tag, ".o_overflow"}, 32'(o_overflow), 32'(eo));
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    i_valid   = 1'b0;
    i_data    = 8'h00;
    i_ready   = 1'b0;

    // fill / full
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h11, 3'd4, 1'b0});
    // overflow attempt with pop: FF dropped, 11 leaves
    vecs.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 3'd0, 1'b1});
    // pop on empty is ignored; stale mem[0] shown
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 3'd0, 1'b1});
    // streaming 0..9, pointers wrap twice
    for (int k = 0; k < 10; k++) begin
      vecs.push_back('{1'b1, 8'(k), 1'b1, 1'b1, 1'b1, 8'(k), 3'd1, 1'b1});
    end
    // final pop; rd_ptr=2 shows stale mem[2]=6
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 3'd0, 1'b1});

    // initial reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].data, vecs[i].ready);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
              vecs[i].e_data, vecs[i].e_count, vecs[i].e_ovf);
    end

    // mid-cycle asynchronous reset clears everything, including the sticky flag
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h78, 1'b0);
    chk("prefill.count", 32'(o_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    rst     = 1'b0;

    // FWFT latency: A5 visible right after its write edge
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    i_ready = 1'b0;
    #1;
    chk("fwft.pre_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    chk_all("fwft", 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0);

    // reset with 3 words held, then first post-reset push is first out
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    chk("t6.count3", 32'(o_count), 32'd3);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    #2;
    chk_all("t6.rst", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    chk_all("t6.push", 1'b1, 1'b1, 8'h5A, 3'd1, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6.pop.count", 32'(o_count), 32'd0);
    chk("t6.pop.valid", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
